// File: rtl/sc_bitstream_encoder.sv
// Binary-to-stochastic encoder: double-buffered input, one frame of 2**width
// low-discrepancy (out1) and unary (out2) bits per value, plus a boundary cycle.
module sc_bitstream_encoder #(
   parameter int width = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width:0]   in_value,
   output logic [width:0]   counter_sob,
   output logic             out1,
   output logic             out2,
   output logic             out_valid,
   output logic             frame_start
);

   localparam logic [width:0] frameLen = {1'b1, {width{1'b0}}};

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [width:0]   counter_q;
   logic [width:0]   cur_q;
   logic [width:0]   shadow_q;
   logic             shadowFull_q;
   logic             shadowFull_d;
   logic             inReady_q;
   logic             out1_q;
   logic             out2_q;
   logic             outValid_q;
   logic             frameStart_q;

   logic             accept;
   logic             atBoundary;
   logic             loadShadow;
   logic [width:0]   nextCount;
   logic [width:0]   inValueSat;

   function automatic logic [width-1:0] revBits(input logic [width-1:0] x);
      logic [width-1:0] r;
      for (int i = 0; i < width; i++) begin
         r[i] = x[width-1-i];
      end
      return r;
   endfunction

   // The shadow is only consumed from IDLE or on the boundary cycle, so a frame is never cut short.
   assign accept       = in_valid && inReady_q;
   assign atBoundary   = (state_q == RUN) && (counter_q == frameLen);
   assign loadShadow   = enable && shadowFull_q && ((state_q == IDLE) || atBoundary);
   assign shadowFull_d = accept ? 1'b1 : (loadShadow ? 1'b0 : shadowFull_q);
   assign nextCount    = counter_q + 1'b1;
   assign inValueSat   = (in_value > frameLen) ? frameLen : in_value;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         counter_q    <= '0;
         cur_q        <= '0;
         shadow_q     <= '0;
         shadowFull_q <= 1'b0;
         inReady_q    <= 1'b1;
         out1_q       <= 1'b0;
         out2_q       <= 1'b0;
         outValid_q   <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         shadowFull_q <= shadowFull_d;
         inReady_q    <= !shadowFull_d;
         if (accept) begin
            shadow_q <= inValueSat;
         end
         out1_q       <= 1'b0;
         out2_q       <= 1'b0;
         outValid_q   <= 1'b0;
         frameStart_q <= 1'b0;
         if (enable) begin
            case (state_q)
               IDLE: begin
                  counter_q <= '0;
                  if (loadShadow) begin
                     cur_q        <= shadow_q;
                     state_q      <= RUN;
                     outValid_q   <= 1'b1;
                     frameStart_q <= 1'b1;
                     out1_q       <= (shadow_q != '0);
                     out2_q       <= (shadow_q != '0);
                  end
               end
               RUN: begin
                  if (atBoundary) begin
                     counter_q <= '0;
                     if (loadShadow) begin
                        cur_q        <= shadow_q;
                        outValid_q   <= 1'b1;
                        frameStart_q <= 1'b1;
                        out1_q       <= (shadow_q != '0);
                        out2_q       <= (shadow_q != '0);
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     counter_q <= nextCount;
                     if (nextCount != frameLen) begin
                        outValid_q <= 1'b1;
                        out1_q     <= ({1'b0, revBits(nextCount[width-1:0])} < cur_q);
                        out2_q     <= ({1'b0, nextCount[width-1:0]} < cur_q);
                     end
                  end
               end
            endcase
         end
      end
   end

   assign in_ready    = inReady_q;
   assign counter_sob = counter_q;
   assign out1        = out1_q;
   assign out2        = out2_q;
   assign out_valid   = outValid_q;
   assign frame_start = frameStart_q;

endmodule

// File: tb/tb_sc_bitstream_encoder.sv
// Directed self-checking bench for sc_bitstream_encoder (width = 5, 32-bit frames).
module tb_sc_bitstream_encoder;

   localparam int W = 5;
   localparam int N = 32;

   logic         clk;
   logic         rst;
   logic         enable;
   logic         in_valid;
   logic         in_ready;
   logic [W:0]   in_value;
   logic [W:0]   counter_sob;
   logic         out1;
   logic         out2;
   logic         out_valid;
   logic         frame_start;

   int errors = 0;
   int checks = 0;

   sc_bitstream_encoder #(.width(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_value    (in_value),
      .counter_sob (counter_sob),
      .out1        (out1),
      .out2        (out2),
      .out_valid   (out_valid),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int rev5(input int x);
      int r = 0;
      for (int b = 0; b < W; b++) begin
         if ((x >> b) & 1) r = r | (1 << (W - 1 - b));
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " out_valid"}, int'(out_valid), 0);
      checkOutput({tag, " counter"}, int'(counter_sob), 0);
      checkOutput({tag, " out1|out2|fs"}, int'(out1 | out2 | frame_start), 0);
   endtask

   // Presents a value on a negedge where in_ready is expected high; returns one
   // cycle after acceptance, i.e. at the negedge of the first data bit when idle.
   task automatic applyStimulus(input int value);
      checkOutput("ready before send", int'(in_ready), 1);
      in_valid = 1'b1;
      in_value = value[W:0];
      @(negedge clk);
      checkOutput("ready after accept", int'(in_ready), 0);
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   // Called at the negedge showing index 0. Ends at the boundary-cycle negedge,
   // or right after an asynchronous reset when abortAt >= 0.
   task automatic runFrame(input int cur, input int pauseAt, input int abortAt);
      int ones1 = 0;
      int ones2 = 0;
      for (int i = 0; i < N; i++) begin
         if (i == abortAt) begin
            rst = 1'b0;
            #1;
            checkOutput("abort out_valid", int'(out_valid), 0);
            checkOutput("abort counter", int'(counter_sob), 0);
            checkOutput("abort ready", int'(in_ready), 1);
            checkOutput("abort bits", int'(out1 | out2 | frame_start), 0);
            @(negedge clk);
            rst = 1'b1;
            return;
         end
         checkOutput($sformatf("valid[%0d]", i), int'(out_valid), 1);
         checkOutput($sformatf("counter[%0d]", i), int'(counter_sob), i);
         checkOutput($sformatf("fs[%0d]", i), int'(frame_start), (i == 0) ? 1 : 0);
         checkOutput($sformatf("out1[%0d]", i), int'(out1), (rev5(i) < cur) ? 1 : 0);
         checkOutput($sformatf("out2[%0d]", i), int'(out2), (i < cur) ? 1 : 0);
         ones1 += int'(out1);
         ones2 += int'(out2);
         if (i == pauseAt) begin
            enable = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               checkOutput("pause counter", int'(counter_sob), pauseAt);
               checkOutput("pause valid", int'(out_valid), 0);
            end
            enable = 1'b1;
         end
         @(negedge clk);
         if (i == 0) in_valid = 1'b0;
      end
      checkOutput("boundary counter", int'(counter_sob), N);
      checkOutput("boundary valid", int'(out_valid), 0);
      checkOutput("ones out1", ones1, cur);
      checkOutput("ones out2", ones2, cur);
   endtask

   initial begin
      rst      = 1'b0;
      enable   = 1'b1;
      in_valid = 1'b0;
      in_value = '0;
      #12;
      checkIdle("reset");
      checkOutput("reset ready", int'(in_ready), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkIdle("idle after reset");

      applyStimulus(0);
      runFrame(0, -1, -1);
      @(negedge clk);
      checkIdle("idle after zero frame");

      applyStimulus(13);
      runFrame(13, -1, -1);
      @(negedge clk);
      checkIdle("idle after 13");

      applyStimulus(40);
      runFrame(32, -1, -1);
      @(negedge clk);

      // back-to-back: 20 offered on frame 1's first data cycle
      applyStimulus(7);
      in_valid = 1'b1;
      in_value = 6'd20;
      runFrame(7, -1, -1);
      checkOutput("b2b shadow held", int'(in_ready), 0);
      @(negedge clk);
      runFrame(20, -1, -1);
      @(negedge clk);
      checkIdle("idle after b2b");

      applyStimulus(20);
      runFrame(20, 9, -1);
      @(negedge clk);

      // a value parked in the shadow must be dropped by reset
      applyStimulus(9);
      in_valid = 1'b1;
      in_value = 6'd3;
      runFrame(9, -1, 17);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkIdle("shadow discarded");
      applyStimulus(5);
      runFrame(5, -1, -1);
      @(negedge clk);
      checkIdle("final idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
